// File: rtl/fetch_buffer_pkg.sv
// Shared CPU front-end definitions: word width, PC step, fetch buffer
// state encoding and entry payload.
package fetch_buffer_pkg;

    localparam int unsigned WORD_WIDTH   = 32;
    localparam int unsigned PC_INCREMENT = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } fb_state_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] instr;
    } fb_entry_t;

    // Sequential PC of the instruction after pc; wraps modulo 2^32.
    function automatic logic [WORD_WIDTH-1:0] next_pc(input logic [WORD_WIDTH-1:0] pc);
        return pc + WORD_WIDTH'(PC_INCREMENT);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order fetch buffer between ProgramCounter/ROM and decode.
// PCWrite is the input-ready, decoded from registered state only.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  inValid,
    input  logic [WORD_WIDTH:1]   currentAddress,
    input  logic [WORD_WIDTH:1]   instruction,
    output logic                  PCWrite,
    input  logic                  Flush,
    input  logic                  outReady,
    output logic                  outValid,
    output logic [WORD_WIDTH:1]   outAddress,
    output logic [WORD_WIDTH:1]   outInstruction,
    output logic [WORD_WIDTH:1]   outNextAddress
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fb_state_t        state;
    fb_state_t        state_nxt;
    fb_entry_t        entries [DEPTH];
    fb_entry_t        head_entry;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push_c;
    logic             pop_c;

    // State register; the state value doubles as the occupancy count.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake decode and next-state; Flush overrides push and pop.
    always_comb begin
        push_c    = inValid && (state != FULL) && !Flush;
        pop_c     = (state != EMPTY) && outReady && !Flush;
        state_nxt = state;
        if (Flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (push_c) state_nxt = ONE;
                ONE: begin
                    if (push_c && !pop_c) begin
                        state_nxt = FULL;
                    end else if (pop_c && !push_c) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL:  if (pop_c) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Head/tail pointers wrap naturally at DEPTH = 2.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            head <= '0;
            tail <= '0;
        end else if (Flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push_c) tail <= tail + PTR_W'(1);
            if (pop_c)  head <= head + PTR_W'(1);
        end
    end

    // Entry payload needs no reset: outputs are masked while EMPTY.
    always_ff @(posedge CLK) begin
        if (push_c) begin
            entries[tail] <= {currentAddress, instruction};
        end
    end

    assign head_entry = entries[head];

    // Output decode from registered state and storage only.
    always_comb begin
        PCWrite        = (state != FULL);
        outValid       = (state != EMPTY);
        outAddress     = '0;
        outInstruction = '0;
        outNextAddress = '0;
        if (state != EMPTY) begin
            outAddress     = head_entry.addr;
            outInstruction = head_entry.instr;
            outNextAddress = next_pc(head_entry.addr);
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed scoreboard bench for fetch_buffer: fill, backpressure, streaming,
// flush, asynchronous reset and address wrap.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
    } exp_t;

    logic        CLK;
    logic        Reset;
    logic        inValid;
    logic [32:1] currentAddress;
    logic [32:1] instruction;
    logic        PCWrite;
    logic        Flush;
    logic        outReady;
    logic        outValid;
    logic [32:1] outAddress;
    logic [32:1] outInstruction;
    logic [32:1] outNextAddress;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    fetch_buffer #(.DEPTH(2)) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .inValid        (inValid),
        .currentAddress (currentAddress),
        .instruction    (instruction),
        .PCWrite        (PCWrite),
        .Flush          (Flush),
        .outReady       (outReady),
        .outValid       (outValid),
        .outAddress     (outAddress),
        .outInstruction (outInstruction),
        .outNextAddress (outNextAddress)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Compare every output against the scoreboard head.
    task automatic check_outputs(input string tag);
        chk({tag, ".outValid"}, 32'(outValid), (sb.size() != 0) ? 32'd1 : 32'd0);
        chk({tag, ".PCWrite"},  32'(PCWrite),  (sb.size() != 2) ? 32'd1 : 32'd0);
        if (sb.size() != 0) begin
            chk({tag, ".outAddress"},     outAddress,     sb[0].addr);
            chk({tag, ".outInstruction"}, outInstruction, sb[0].instr);
            chk({tag, ".outNextAddress"}, outNextAddress, sb[0].addr + 32'd4);
        end else begin
            chk({tag, ".outAddress"},     outAddress,     32'd0);
            chk({tag, ".outInstruction"}, outInstruction, 32'd0);
            chk({tag, ".outNextAddress"}, outNextAddress, 32'd0);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] a);
        inValid        = v;
        currentAddress = a;
        instruction    = instr_of(a);
    endtask

    // Update the scoreboard from the inputs held across the coming edge.
    task automatic tick(output bit accepted);
        int n;
        bit push;
        bit pop;
        n        = sb.size();
        push     = inValid && (n < 2) && !Flush;
        pop      = (n > 0) && outReady && !Flush;
        accepted = push;
        if (Flush) begin
            sb.delete();
        end else begin
            if (pop)  sb.delete(0);
            if (push) sb.push_back('{currentAddress, instruction});
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bit          acc;
        logic [31:0] a;

        Reset    = 1'b1;
        Flush    = 1'b0;
        outReady = 1'b0;
        set_in(1'b0, 32'd0);
        #2;
        check_outputs("reset");
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        check_outputs("post_reset");

        // Fill: 0, 4 accepted, 8 refused while full.
        a = 32'd0;
        set_in(1'b1, a);
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            if (acc) a = a + 32'd4;
            set_in(1'b1, a);
            check_outputs("fill");
        end
        chk("fill.pcwrite_low", 32'(PCWrite), 32'd0);
        chk("fill.head_addr", outAddress, 32'd0);
        chk("fill.pc_held", a, 32'd8);

        // Backpressure: outReady 0,0,1 then drain.
        set_in(1'b0, 32'd0);
        outReady = 1'b0;
        tick(acc);
        check_outputs("bp_hold0");
        tick(acc);
        check_outputs("bp_hold1");
        chk("bp.stable_addr", outAddress, 32'd0);
        outReady = 1'b1;
        tick(acc);
        check_outputs("bp_advance");
        chk("bp.second_entry", outAddress, 32'd4);
        tick(acc);
        check_outputs("bp_drained");

        // Streaming from 0x100 with decode always ready.
        a        = 32'h100;
        outReady = 1'b1;
        set_in(1'b1, a);
        for (int i = 0; i < 8; i++) begin
            tick(acc);
            if (acc) a = a + 32'd4;
            set_in(1'b1, a);
            check_outputs("stream");
            chk("stream.addr", outAddress, 32'h100 + 32'(i) * 32'd4);
        end
        set_in(1'b0, 32'd0);
        tick(acc);
        check_outputs("stream_end");

        // Flush from FULL with a simultaneous incoming fetch.
        outReady = 1'b0;
        set_in(1'b1, 32'h20);
        tick(acc);
        set_in(1'b1, 32'h24);
        tick(acc);
        check_outputs("flush_full");
        Flush = 1'b1;
        set_in(1'b1, 32'h40);
        tick(acc);
        Flush = 1'b0;
        set_in(1'b0, 32'd0);
        check_outputs("flush_after");
        tick(acc);
        check_outputs("flush_idle");

        // Asynchronous reset pulsed between edges while ONE.
        set_in(1'b1, 32'h200);
        tick(acc);
        set_in(1'b0, 32'd0);
        check_outputs("areset_one");
        #3;
        Reset = 1'b1;
        sb.delete();
        #1;
        check_outputs("areset_async");
        #1;
        Reset = 1'b0;
        tick(acc);
        check_outputs("areset_after0");
        tick(acc);
        check_outputs("areset_after1");

        // Next-address wrap at the top of the address space.
        set_in(1'b1, 32'hFFFF_FFFC);
        tick(acc);
        set_in(1'b0, 32'd0);
        check_outputs("wrap");
        chk("wrap.next", outNextAddress, 32'h0000_0000);
        outReady = 1'b1;
        tick(acc);
        check_outputs("wrap_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of buffered fetch entries; only the value 2 is supported.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port inValid, input, 1 bit: the fetched address/instruction pair this cycle is valid.
REQ-005 SHALL have port currentAddress, input, bits [32:1]: PC of the fetched instruction, driven by the program counter.
REQ-006 SHALL have port instruction, input, bits [32:1]: ROM word for currentAddress.
REQ-007 SHALL have port PCWrite, output, 1 bit: enables the program counter to advance; acts as the input-ready signal.
REQ-008 SHALL have port Flush, input, 1 bit: discards all buffered and incoming entries (branch/jump redirect).
REQ-009 SHALL have port outReady, input, 1 bit: the decode stage accepts the head entry this cycle.
REQ-010 SHALL have port outValid, output, 1 bit: the head entry is valid.
REQ-011 SHALL have port outAddress, output, bits [32:1]: PC of the head entry.
REQ-012 SHALL have port outInstruction, output, bits [32:1]: instruction of the head entry.
REQ-013 SHALL have port outNextAddress, output, bits [32:1]: outAddress + 4, modulo 2^32.

Function
REQ-014 SHALL operate as a 2-entry in-order FIFO with states EMPTY (count 0), ONE (count 1) and FULL (count 2).
REQ-015 SHALL drive PCWrite = 1 exactly when state != FULL, decoded from registered state only; PCWrite SHALL have no combinational path from outReady.
REQ-016 SHALL push an entry when inValid & PCWrite & !Flush.
REQ-017 SHALL pop the head entry when outValid & outReady & !Flush.
REQ-018 SHALL apply these transitions:
- EMPTY + push -> ONE
- ONE + push only -> FULL
- ONE + pop only -> EMPTY
- ONE + push and pop -> ONE, with the new entry as head
- FULL + pop -> ONE
- no push and no pop -> state unchanged
REQ-019 SHALL have latency 1: an entry pushed at edge N appears on the out* ports after edge N; there SHALL be no input-to-output bypass.
REQ-020 SHALL drive outValid = 1 exactly when state != EMPTY.
REQ-021 SHALL make Flush take priority over push and pop: at the next edge the state SHALL be EMPTY and that cycle's input SHALL be discarded.
REQ-022 SHALL hold the out* data ports stable while outValid = 1 and outReady = 0.
REQ-023 SHALL clear outAddress, outInstruction and outNextAddress to 0 whenever the state is EMPTY.
REQ-024 SHALL compute outNextAddress with 32-bit wrap, e.g. 32'hFFFFFFFC + 4 = 32'h00000000.

Reset
REQ-025 SHALL, while Reset = 1, immediately force state EMPTY, outValid = 0, out* data ports = 0 and PCWrite = 1, independent of CLK.
REQ-026 SHALL, on Reset asserted mid-operation, discard all buffered entries; no entry SHALL be presented after Reset deasserts until a new push.

Structure
REQ-027 SHALL place in the shared CPU package the constants WORD_WIDTH = 32, PC_INCREMENT = 4, and the state encodings EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b10.
REQ-028 SHALL have no sub-modules: storage is two entry registers plus head/tail pointer bits and a 2-bit count.
REQ-029 SHALL be instantiated between ProgramCounter/ROM and the decode stage, with PCWrite wired to ProgramCounter.PCWrite.

Verification
REQ-030 SHALL verify basic fill: after reset, inValid = 1 with addresses 0, 4, 8 and outReady = 0 -> FULL after 2 edges, PCWrite = 0, outAddress = 0, address 8 not accepted.
REQ-031 SHALL verify streaming: inValid = 1 and outReady = 1 continuously from address 0x100 -> outAddress = 0x100, 0x104, ... one per cycle after 1-cycle latency, state stays ONE.
REQ-032 SHALL verify flush: FULL with entries 0x20/0x24, then Flush = 1 with inValid = 1 at 0x40 -> next cycle EMPTY, outValid = 0, 0x40 dropped, PCWrite = 1.
REQ-033 SHALL verify async reset: Reset pulsed mid-cycle while state is ONE -> outValid = 0 and PCWrite = 1 before the next CLK edge; afterwards outValid = 0 until a push.
REQ-034 SHALL verify wrap: push currentAddress = 32'hFFFFFFFC -> outNextAddress = 32'h00000000.
REQ-035 SHALL verify backpressure stability: FULL, outReady toggling 0,0,1 -> out* unchanged for 2 cycles, then advances to the second entry; order preserved.
